// File: rtl/pong_game_pkg.sv
// Shared definitions for the pong match controller: state encoding, key
// codes, serve/winner direction constants and a small sizing helper.
package pong_game_pkg;

   localparam int STATE_W = 3;

   localparam logic [STATE_W-1:0] ENC_IDLE      = 3'd0;
   localparam logic [STATE_W-1:0] ENC_SERVE     = 3'd1;
   localparam logic [STATE_W-1:0] ENC_PLAY      = 3'd2;
   localparam logic [STATE_W-1:0] ENC_POINT     = 3'd3;
   localparam logic [STATE_W-1:0] ENC_GAME_OVER = 3'd4;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE      = ENC_IDLE,
      ST_SERVE     = ENC_SERVE,
      ST_PLAY      = ENC_PLAY,
      ST_POINT     = ENC_POINT,
      ST_GAME_OVER = ENC_GAME_OVER
   } state_t;

   localparam logic [7:0] KEY_SPACE = 8'd32;
   localparam logic [7:0] KEY_W     = 8'd119;
   localparam logic [7:0] KEY_S     = 8'd115;
   localparam logic [7:0] KEY_I     = 8'd105;
   localparam logic [7:0] KEY_K     = 8'd107;

   // serve direction points at the player who conceded the last point
   localparam logic SERVE_TO_P1 = 1'b0;
   localparam logic SERVE_TO_P2 = 1'b1;

   localparam logic WINNER_P1 = 1'b0;
   localparam logic WINNER_P2 = 1'b1;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pong_game_controller_tick_countdown.sv
// Down-counter used for the serve hold-off and the optional point timeout.
// Load has priority over decrement; the count stops at zero.
module tick_countdown #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_value,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count;

   // count register: load, else decrement while non-zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/pong_game_controller.sv
// Match-level pong controller on the 30 Hz game tick. Tracks both scores,
// detects the winner and sequences idle/serve/play/point/game-over, driving
// the ball engine controls. Optional build macro GAME_AUTO_SERVE_EN adds a
// timeout that leaves POINT automatically after AUTO_SERVE_TICKS ticks.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   IDLE      | power-up, ball held at centre, wait for start key
//   SERVE     | ball held at centre for SERVE_TICKS ticks, then launch
//   PLAY      | rally in progress, scored pulses are counted
//   POINT     | rally over, ball held, wait for start key (or timeout)
//   GAME_OVER | someone reached WIN_SCORE, winner shown, start key resets
module pong_game_controller
   import pong_game_pkg::*;
#(
   parameter int SCORE_W          = 4,
   parameter int WIN_SCORE        = 7,
   parameter int SERVE_TICKS      = 60,
   parameter int START_KEY        = 32,
   parameter int AUTO_SERVE_TICKS = 150
) (
   input  logic               i_CLK,
   input  logic               i_RST,
   input  logic [7:0]         i_key_byte,
   input  logic               i_p1_scored,
   input  logic               i_p2_scored,
   output logic [2:0]         o_state,
   output logic               o_ball_enable,
   output logic               o_ball_reset,
   output logic               o_serve_dir,
   output logic [SCORE_W-1:0] o_p1_score,
   output logic [SCORE_W-1:0] o_p2_score,
   output logic               o_game_over,
   output logic               o_winner
);

   localparam int TIMER_W = $clog2(max_int(SERVE_TICKS, AUTO_SERVE_TICKS) + 1);
   localparam logic [TIMER_W-1:0] SERVE_LOAD = TIMER_W'(SERVE_TICKS - 1);
   localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
   localparam logic [7:0]         START_VAL  = 8'(START_KEY);
`ifdef GAME_AUTO_SERVE_EN
   localparam logic [TIMER_W-1:0] AUTO_LOAD  = TIMER_W'(AUTO_SERVE_TICKS - 1);
`endif

   state_t               state;
   state_t               next_state;
   logic                 armed;
   logic                 start_evt;
   logic                 timer_load;
   logic [TIMER_W-1:0]   timer_load_value;
   logic                 timer_dec;
   logic                 timer_zero;

   logic [SCORE_W-1:0]   p1_score;
   logic [SCORE_W-1:0]   p2_score;
   logic [SCORE_W-1:0]   p1_next;
   logic [SCORE_W-1:0]   p2_next;
   logic                 serve_dir;
   logic                 dir_next;
   logic                 winner;
   logic                 winner_next;
   logic                 ball_enable;
   logic                 ball_reset;
   logic                 game_over;

   // a start key only counts after the byte has been seen at something else
   assign start_evt = armed && (i_key_byte == START_VAL);

   tick_countdown #(
      .W (TIMER_W)
   ) u_timer (
      .clk        (i_CLK),
      .rst        (i_RST),
      .load       (timer_load),
      .load_value (timer_load_value),
      .dec        (timer_dec),
      .zero       (timer_zero)
   );

   // next-state, score and timer control
   always_comb begin
      next_state       = state;
      p1_next          = p1_score;
      p2_next          = p2_score;
      dir_next         = serve_dir;
      winner_next      = winner;
      timer_load       = 1'b0;
      timer_load_value = SERVE_LOAD;
      timer_dec        = 1'b0;

      case (state)
         ST_IDLE: begin
            if (start_evt) next_state = ST_SERVE;
         end
         ST_SERVE: begin
            if (timer_zero) next_state = ST_PLAY;
            else            timer_dec  = 1'b1;
         end
         ST_PLAY: begin
            if (i_p1_scored && i_p2_scored) begin
               // simultaneous pulses: no point awarded
               next_state = ST_POINT;
            end else if (i_p1_scored) begin
               dir_next = SERVE_TO_P2;
               if (p1_score >= WIN_VAL - 1'b1) begin
                  p1_next     = WIN_VAL;
                  winner_next = WINNER_P1;
                  next_state  = ST_GAME_OVER;
               end else begin
                  p1_next    = p1_score + 1'b1;
                  next_state = ST_POINT;
               end
            end else if (i_p2_scored) begin
               dir_next = SERVE_TO_P1;
               if (p2_score >= WIN_VAL - 1'b1) begin
                  p2_next     = WIN_VAL;
                  winner_next = WINNER_P2;
                  next_state  = ST_GAME_OVER;
               end else begin
                  p2_next    = p2_score + 1'b1;
                  next_state = ST_POINT;
               end
            end
         end
         ST_POINT: begin
            if (start_evt) begin
               next_state = ST_SERVE;
`ifdef GAME_AUTO_SERVE_EN
            end else if (timer_zero) begin
               next_state = ST_SERVE;
            end else begin
               timer_dec = 1'b1;
`endif
            end
         end
         ST_GAME_OVER: begin
            if (start_evt) begin
               p1_next    = '0;
               p2_next    = '0;
               next_state = ST_SERVE;
            end
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase

      if (next_state != state) begin
         if (next_state == ST_SERVE) begin
            timer_load       = 1'b1;
            timer_load_value = SERVE_LOAD;
         end
`ifdef GAME_AUTO_SERVE_EN
         if (next_state == ST_POINT) begin
            timer_load       = 1'b1;
            timer_load_value = AUTO_LOAD;
         end
`endif
      end
   end

   // state register
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) state <= ST_IDLE;
      else       state <= next_state;
   end

   // start-key arming: cleared on any state entry, set once the key leaves START_KEY
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         armed <= 1'b0;
      end else if (next_state != state) begin
         armed <= 1'b0;
      end else if (i_key_byte != START_VAL) begin
         armed <= 1'b1;
      end
   end

   // registered match outputs, decoded from the state being entered
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         p1_score    <= '0;
         p2_score    <= '0;
         serve_dir   <= SERVE_TO_P1;
         winner      <= WINNER_P1;
         ball_enable <= 1'b0;
         ball_reset  <= 1'b1;
         game_over   <= 1'b0;
      end else begin
         p1_score    <= p1_next;
         p2_score    <= p2_next;
         serve_dir   <= dir_next;
         winner      <= winner_next;
         ball_enable <= (next_state == ST_PLAY);
         ball_reset  <= (next_state != ST_PLAY);
         game_over   <= (next_state == ST_GAME_OVER);
      end
   end

   assign o_state       = state;
   assign o_ball_enable = ball_enable;
   assign o_ball_reset  = ball_reset;
   assign o_serve_dir   = serve_dir;
   assign o_p1_score    = p1_score;
   assign o_p2_score    = p2_score;
   assign o_game_over   = game_over;
   assign o_winner      = winner;

endmodule
